// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN elevator controller with latched calls, travel timing and door dwell
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_FLOORS-1:0] interior_panel,
    input  logic [NUM_FLOORS-1:0] exterior_panel,
    output logic [1:0]            engine,
    output logic [NUM_FLOORS-1:0] doors,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0]      TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0]      DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP         = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    state_t                state;
    logic                  dir;
    logic [CW-1:0]         travel_cnt, door_cnt;
    logic [NUM_FLOORS-1:0] press, here, next_here, clear;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  dir_here, dir_next;
    logic                  ahead_up, ahead_dn, ahead_up_next, ahead_dn_next;
    logic                  can_move_here, move_dir_here, can_move_next, move_dir_next;
    logic                  call_here, stop_next, door_press;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) > f) r = r | v[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) < f) r = r | v[i];
        return r;
    endfunction

    // Direction is pinned at the end floors so the cabin can never run off the shaft
    function automatic logic forced_dir(input logic [FLOOR_W-1:0] f, input logic d);
        return (f == TOP) ? 1'b1 : (f == '0) ? 1'b0 : d;
    endfunction

    always_comb begin
        press         = interior_panel | exterior_panel;
        here          = onehot(current_floor);
        next_floor    = dir ? current_floor - FLOOR_W'(1) : current_floor + FLOOR_W'(1);
        next_here     = onehot(next_floor);
        dir_here      = forced_dir(current_floor, dir);
        dir_next      = forced_dir(next_floor, dir);
        ahead_up      = any_above(pending, current_floor);
        ahead_dn      = any_below(pending, current_floor);
        ahead_up_next = any_above(pending, next_floor);
        ahead_dn_next = any_below(pending, next_floor);
        can_move_here = ahead_up | ahead_dn;
        move_dir_here = dir_here ? ahead_dn : !ahead_up;
        can_move_next = ahead_up_next | ahead_dn_next;
        move_dir_next = dir_next ? ahead_dn_next : !ahead_up_next;
        call_here     = |((pending | press) & here);
        stop_next     = |(pending & next_here);
        door_press    = |(press & here);
        clear         = (state == DOOR_OPEN || (state == IDLE && call_here)) ? here :
                        (state == MOVING && travel_cnt == '0 && stop_next) ? next_here : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= IDLE;
            current_floor <= '0;
            dir           <= 1'b0;
            pending       <= '0;
            engine        <= 2'b00;
            doors         <= '0;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else begin
            pending <= (pending | press) & ~clear;
            case (state)
                IDLE: begin
                    if (call_here) begin
                        state    <= DOOR_OPEN;
                        door_cnt <= DOOR_LOAD;
                        doors    <= here;
                    end else if (can_move_here) begin
                        state      <= MOVING;
                        dir        <= move_dir_here;
                        travel_cnt <= TRAVEL_LOAD;
                        engine     <= {1'b1, move_dir_here};
                    end
                end
                MOVING: begin
                    if (travel_cnt != '0) begin
                        travel_cnt <= travel_cnt - CW'(1);
                    end else begin
                        current_floor <= next_floor;
                        if (stop_next) begin
                            state    <= DOOR_OPEN;
                            dir      <= dir_next;
                            door_cnt <= DOOR_LOAD;
                            doors    <= next_here;
                            engine   <= 2'b00;
                        end else if (can_move_next) begin
                            dir        <= move_dir_next;
                            travel_cnt <= TRAVEL_LOAD;
                            engine     <= {1'b1, move_dir_next};
                        end else begin
                            state  <= IDLE;
                            dir    <= dir_next;
                            engine <= 2'b00;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (door_press) begin
                        door_cnt <= DOOR_LOAD;
                    end else if (door_cnt != '0) begin
                        door_cnt <= door_cnt - CW'(1);
                    end else begin
                        doors <= '0;
                        if (can_move_here) begin
                            state      <= MOVING;
                            dir        <= move_dir_here;
                            travel_cnt <= TRAVEL_LOAD;
                            engine     <= {1'b1, move_dir_here};
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    engine <= 2'b00;
                    doors  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: scoreboard bench, per-cycle expected outputs queued with each stimulus step
module tb_elevator_scan_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] interior_panel = '0;
    logic [3:0] exterior_panel = '0;
    logic [1:0] engine;
    logic [3:0] doors;
    logic [1:0] current_floor;
    logic [3:0] pending;
    int         checks = 0;
    int         errors = 0;
    string      phase = "init";

    typedef struct packed {
        logic [1:0] eng;
        logic [3:0] doors;
        logic [1:0] fl;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    exp_t mon;

    elevator_scan_ctrl #(
        .NUM_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .interior_panel(interior_panel), .exterior_panel(exterior_panel),
        .engine(engine), .doors(doors), .current_floor(current_floor), .pending(pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got %0h expected %0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] ip, input logic [3:0] ep,
                        input logic [1:0] eng, input logic [3:0] dr, input logic [1:0] fl,
                        input logic [3:0] pd);
        exp_t e;
        @(negedge CLK);
        RST = r;
        interior_panel = ip;
        exterior_panel = ep;
        e.eng = eng;
        e.doors = dr;
        e.fl = fl;
        e.pend = pd;
        sb.push_back(e);
    endtask

    task automatic hold(input int n, input logic [1:0] eng, input logic [3:0] dr,
                        input logic [1:0] fl, input logic [3:0] pd);
        for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 4'b0000, eng, dr, fl, pd);
    endtask

    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            mon = sb.pop_front();
            check("engine", 32'(engine), 32'(mon.eng));
            check("doors", 32'(doors), 32'(mon.doors));
            check("floor", 32'(current_floor), 32'(mon.fl));
            check("pending", 32'(pending), 32'(mon.pend));
        end
    end

    initial begin
        phase = "reset";
        step(1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'd0, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'd0, 4'b0000);

        phase = "door_at_0";
        step(1'b1, 4'b0001, 4'b0000, 2'b00, 4'b0001, 2'd0, 4'b0000);
        hold(3, 2'b00, 4'b0001, 2'd0, 4'b0000);
        hold(2, 2'b00, 4'b0000, 2'd0, 4'b0000);

        phase = "call_2";
        step(1'b1, 4'b0000, 4'b0100, 2'b00, 4'b0000, 2'd0, 4'b0100);
        hold(8, 2'b10, 4'b0000, 2'd0, 4'b0100);
        hold(8, 2'b10, 4'b0000, 2'd1, 4'b0100);
        hold(4, 2'b00, 4'b0100, 2'd2, 4'b0000);
        hold(2, 2'b00, 4'b0000, 2'd2, 4'b0000);

        phase = "door_extend";
        step(1'b1, 4'b0000, 4'b0100, 2'b00, 4'b0100, 2'd2, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000, 2'b00, 4'b0100, 2'd2, 4'b0000);
        step(1'b1, 4'b0000, 4'b0100, 2'b00, 4'b0100, 2'd2, 4'b0000);
        hold(3, 2'b00, 4'b0100, 2'd2, 4'b0000);
        hold(2, 2'b00, 4'b0000, 2'd2, 4'b0000);

        phase = "to_top";
        step(1'b1, 4'b0000, 4'b1000, 2'b00, 4'b0000, 2'd2, 4'b1000);
        hold(8, 2'b10, 4'b0000, 2'd2, 4'b1000);
        hold(4, 2'b00, 4'b1000, 2'd3, 4'b0000);
        hold(1, 2'b00, 4'b0000, 2'd3, 4'b0000);

        phase = "top_then_down";
        step(1'b1, 4'b1010, 4'b0000, 2'b00, 4'b1000, 2'd3, 4'b0010);
        hold(3, 2'b00, 4'b1000, 2'd3, 4'b0010);
        hold(8, 2'b11, 4'b0000, 2'd3, 4'b0010);
        hold(8, 2'b11, 4'b0000, 2'd2, 4'b0010);
        hold(4, 2'b00, 4'b0010, 2'd1, 4'b0000);
        hold(2, 2'b00, 4'b0000, 2'd1, 4'b0000);

        phase = "reset_moving";
        step(1'b1, 4'b0000, 4'b1000, 2'b00, 4'b0000, 2'd1, 4'b1000);
        hold(8, 2'b10, 4'b0000, 2'd1, 4'b1000);
        hold(3, 2'b10, 4'b0000, 2'd2, 4'b1000);
        step(1'b0, 4'b0000, 4'b0100, 2'b00, 4'b0000, 2'd0, 4'b0000);
        hold(3, 2'b00, 4'b0000, 2'd0, 4'b0000);

        phase = "scan";
        step(1'b1, 4'b0000, 4'b1000, 2'b00, 4'b0000, 2'd0, 4'b1000);
        hold(8, 2'b10, 4'b0000, 2'd0, 4'b1000);
        hold(1, 2'b10, 4'b0000, 2'd1, 4'b1000);
        step(1'b1, 4'b0000, 4'b1001, 2'b10, 4'b0000, 2'd1, 4'b1001);
        hold(6, 2'b10, 4'b0000, 2'd1, 4'b1001);
        hold(8, 2'b10, 4'b0000, 2'd2, 4'b1001);
        hold(4, 2'b00, 4'b1000, 2'd3, 4'b0001);
        hold(8, 2'b11, 4'b0000, 2'd3, 4'b0001);
        hold(8, 2'b11, 4'b0000, 2'd2, 4'b0001);
        hold(8, 2'b11, 4'b0000, 2'd1, 4'b0001);
        hold(4, 2'b00, 4'b0001, 2'd0, 4'b0000);
        hold(2, 2'b00, 4'b0000, 2'd0, 4'b0000);

        @(negedge CLK);
        phase = "end";
        check("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
